// File: rtl/mesh_term_src.sv
// Mesh terminal source: assembles packets and queues them in a circular FIFO for the mesh.
// Optional statistics counters are enabled by defining MESH_TERM_STATS_EN.
module mesh_term_src #(
  parameter int unsigned pckg_sz    = 40,
  parameter int unsigned fifo_depth = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [3:0]         dest_row,
  input  logic [3:0]         dest_col,
  input  logic               mode,
  input  logic [pckg_sz-18:0] payload,
  input  logic               popin,
  output logic [pckg_sz-1:0] data_out_i_in,
  output logic               pndng_i_in,
  output logic               full,
  output logic               overflow,
  output logic [15:0]        sent_cnt,
  output logic [15:0]        drop_cnt
);

  localparam int unsigned PtrW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int unsigned CntW = $clog2(fifo_depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(fifo_depth - 1);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(fifo_depth);

  logic [pckg_sz-1:0] mem_q [fifo_depth];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               overflow_q, overflow_d;

  logic               do_push, do_pop, do_drop;
  logic [pckg_sz-1:0] pkt;

  // Next-jump byte is left zero for the router to fill in.
  assign pkt = {8'h00, dest_row, dest_col, mode, payload};

  assign full       = (count_q == MaxCnt);
  assign pndng_i_in = (count_q != '0);

  // A pop in the same cycle frees the slot, so a push into a full queue still lands.
  assign do_pop  = popin && pndng_i_in;
  assign do_push = push && (!full || do_pop);
  assign do_drop = push && !do_push;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = do_drop;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; the head is masked to zero whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem_q[wr_ptr_q] <= pkt;
    end
  end

  assign data_out_i_in = pndng_i_in ? mem_q[rd_ptr_q] : '0;
  assign overflow      = overflow_q;

`ifdef MESH_TERM_STATS_EN
  logic [15:0] sent_cnt_q, drop_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sent_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (do_pop && (sent_cnt_q != 16'hFFFF)) begin
        sent_cnt_q <= sent_cnt_q + 16'd1;
      end
      if (do_drop && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  assign sent_cnt = sent_cnt_q;
  assign drop_cnt = drop_cnt_q;
`else
  assign sent_cnt = 16'h0000;
  assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mesh_term_src.sv
// Self-checking bench for mesh_term_src: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_mesh_term_src;

  localparam int unsigned PckgSz = 40;
  localparam int unsigned Depth  = 4;

  logic              clk = 1'b0;
  logic              reset, push, mode, popin;
  logic [3:0]        dest_row, dest_col;
  logic [PckgSz-18:0] payload;
  logic [PckgSz-1:0] data_out_i_in;
  logic              pndng_i_in, full, overflow;
  logic [15:0]       sent_cnt, drop_cnt;

  mesh_term_src #(
    .pckg_sz   (PckgSz),
    .fifo_depth(Depth)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .dest_row     (dest_row),
    .dest_col     (dest_col),
    .mode         (mode),
    .payload      (payload),
    .popin        (popin),
    .data_out_i_in(data_out_i_in),
    .pndng_i_in   (pndng_i_in),
    .full         (full),
    .overflow     (overflow),
    .sent_cnt     (sent_cnt),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [PckgSz-1:0] model_q[$];
  bit                ovf_m;
  int                sent_m, drop_m;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [PckgSz-1:0] mk_pkt(input logic [3:0] r, input logic [3:0] c,
                                               input logic m, input logic [PckgSz-18:0] pl);
    return {8'h00, r, c, m, pl};
  endfunction

  task automatic step(input bit rst, input bit ps, input logic [3:0] r, input logic [3:0] c,
                      input bit m, input logic [PckgSz-18:0] pl, input bit pop);
    bit popped;
    reset    = rst;
    push     = ps;
    dest_row = r;
    dest_col = c;
    mode     = m;
    payload  = pl;
    popin    = pop;
    @(posedge clk);
    if (rst) begin
      model_q.delete();
      ovf_m  = 0;
      sent_m = 0;
      drop_m = 0;
    end else begin
      popped = pop && (model_q.size() != 0);
      if (popped) begin
        void'(model_q.pop_front());
        if (sent_m < 65535) sent_m++;
      end
      if (ps && model_q.size() < Depth) begin
        model_q.push_back(mk_pkt(r, c, m, pl));
        ovf_m = 0;
      end else begin
        ovf_m = ps;
        if (ps && drop_m < 65535) drop_m++;
      end
    end
    #1;
    check("pndng", 64'(pndng_i_in), 64'(model_q.size() != 0));
    check("full", 64'(full), 64'(model_q.size() == Depth));
    check("overflow", 64'(overflow), 64'(ovf_m));
    check("data_out", 64'(data_out_i_in), (model_q.size() != 0) ? 64'(model_q[0]) : 64'd0);
`ifdef MESH_TERM_STATS_EN
    check("sent_cnt", 64'(sent_cnt), 64'(sent_m));
    check("drop_cnt", 64'(drop_cnt), 64'(drop_m));
`else
    check("sent_cnt", 64'(sent_cnt), 64'd0);
    check("drop_cnt", 64'(drop_cnt), 64'd0);
`endif
  endtask

  task automatic push_pl(input int pl, input bit pop);
    step(0, 1, 4'd1, 4'd2, 1'b0, 23'(pl), pop);
  endtask

  task automatic idle(input bit pop);
    step(0, 0, 4'd0, 4'd0, 1'b0, 23'd0, pop);
  endtask

  initial begin
    reset = 1; push = 0; popin = 0; mode = 0;
    dest_row = '0; dest_col = '0; payload = '0;

    // Reset state
    step(1, 0, 4'd0, 4'd0, 1'b0, 23'd0, 0);
    step(1, 0, 4'd0, 4'd0, 1'b0, 23'd0, 0);

    // Single packet with field layout
    step(0, 1, 4'd2, 4'd3, 1'b1, 23'd0, 0);
    check("pkt_fields", 64'(data_out_i_in), 64'(mk_pkt(4'd2, 4'd3, 1'b1, 23'd0)));
    idle(1);

    // Fill, overflow, then drain in order
    for (int i = 1; i <= 4; i++) push_pl(i, 0);
    push_pl(99, 0);
    idle(0);
    for (int i = 0; i < 4; i++) idle(1);

    // Full queue with simultaneous push and pop
    for (int i = 1; i <= 4; i++) push_pl(i, 0);
    push_pl(5, 1);
    check("head_after_swap", 64'(data_out_i_in[22:0]), 64'd2);
    for (int i = 0; i < 4; i++) idle(1);

    // Pop while empty, then push+pop while empty
    for (int i = 0; i < 3; i++) idle(1);
    push_pl(7, 1);
    idle(1);

    // Mid-operation reset with a push pending
    for (int i = 1; i <= 3; i++) push_pl(i, 0);
    step(1, 1, 4'd5, 4'd5, 1'b1, 23'd42, 0);
    idle(0);

    // Streaming push/pop pairs across pointer wrap
    push_pl(100, 0);
    for (int i = 1; i <= 10; i++) push_pl(100 + i, 1);
    idle(1);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 79) == 0, $urandom_range(0, 99) < 60,
           4'($urandom), 4'($urandom), 1'($urandom), 23'($urandom),
           $urandom_range(0, 99) < 50);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
